// File: rtl/rf_wb_arbiter_if.sv
// Requester-side handshake bundle for the register-file writeback arbiter.
// Two requesters (0 = ALU writeback, 1 = load / multi-cycle writeback) each
// present valid/rd/data and receive a combinational ready.
//   master : the requester side (drives valid/rd/data, samples ready)
//   slave  : the arbiter side (samples valid/rd/data, drives ready)
interface rf_wb_arbiter_if #(
  parameter int n = 32
);
  logic         req0_valid;
  logic [4:0]   req0_rd;
  logic [n-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [4:0]   req1_rd;
  logic [n-1:0] req1_data;
  logic         req1_ready;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Arbitrates two writeback requesters onto a single registered write port with
// round-robin priority, and can run a clear sequence that zeroes x1..x31 on 31
// consecutive cycles.
// Ports:
//   clk        : clock, all state updates on posedge
//   rst        : synchronous active-low reset
//   bus        : requester handshakes (slave side)
//   clr_start  : request to zero x1..x31
//   clr_busy   : clear sequence in progress
//   Wr_en      : registered write enable
//   rd         : registered write address
//   Wr_data    : registered write data
//   last_grant : index of most recently granted requester
module rf_wb_arbiter #(
  parameter int n = 32
) (
  input  logic             clk,
  input  logic             rst,
  rf_wb_arbiter_if.slave   bus,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             Wr_en,
  output logic [4:0]       rd,
  output logic [n-1:0]     Wr_data,
  output logic             last_grant
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  state_t       state_reg, state_next;
  logic         prio_reg, prio_next;
  logic [4:0]   idx_reg, idx_next;
  logic         wr_en_reg, wr_en_next;
  logic [4:0]   rd_reg, rd_next;
  logic [n-1:0] data_reg, data_next;
  logic         last_reg, last_next;

  logic [1:0]   valid;
  logic [1:0]   ready;
  logic [4:0]   req_rd   [2];
  logic [n-1:0] req_data [2];
  logic         hs;
  logic         grant;

  assign valid       = {bus.req1_valid, bus.req0_valid};
  assign req_rd[0]   = bus.req0_rd;
  assign req_rd[1]   = bus.req1_rd;
  assign req_data[0] = bus.req0_data;
  assign req_data[1] = bus.req1_data;

  // A requester wins when it is alone or holds priority; clear requests and
  // reset block every grant, so at most one ready can be high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign ready[gi] = rst && (state_reg == ARB) && !clr_start && valid[gi] &&
                       (!valid[1-gi] || (prio_reg == 1'(gi)));
  end

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign hs             = |ready;
  assign grant          = ready[1];

  // State register (also holds the registered outputs and counters).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ARB;
      prio_reg  <= 1'b0;
      idx_reg   <= 5'd0;
      wr_en_reg <= 1'b0;
      rd_reg    <= 5'd0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      prio_reg  <= prio_next;
      idx_reg   <= idx_next;
      wr_en_reg <= wr_en_next;
      rd_reg    <= rd_next;
      data_reg  <= data_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB:     if (clr_start) state_next = CLEAR;
      CLEAR:   if (idx_reg == 5'd31) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Output / datapath logic; rd and data hold whenever no write is issued.
  always_comb begin
    prio_next  = prio_reg;
    idx_next   = idx_reg;
    wr_en_next = 1'b0;
    rd_next    = rd_reg;
    data_next  = data_reg;
    last_next  = last_reg;
    case (state_reg)
      ARB: begin
        if (clr_start) begin
          idx_next = 5'd1;
        end else if (hs) begin
          prio_next = ~grant;
          last_next = grant;
          // A write to x0 is consumed but never reaches the register file.
          if (req_rd[grant] != 5'd0) begin
            wr_en_next = 1'b1;
            rd_next    = req_rd[grant];
            data_next  = req_data[grant];
          end
        end
      end
      CLEAR: begin
        wr_en_next = 1'b1;
        rd_next    = idx_reg;
        data_next  = '0;
        idx_next   = idx_reg + 5'd1;
      end
      default: ;
    endcase
  end

  assign clr_busy   = (state_reg == CLEAR);
  assign Wr_en      = wr_en_reg;
  assign rd         = rd_reg;
  assign Wr_data    = data_reg;
  assign last_grant = last_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic        clr_busy;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        last_grant;

  rf_wb_arbiter_if #(.n(32)) bus ();

  rf_wb_arbiter #(.n(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .Wr_en      (wr_en),
    .rd         (wr_rd),
    .Wr_data    (wr_data),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Pending requests held by the bench-side requesters.
  logic [1:0]  p_valid;
  logic [4:0]  p_rd   [2];
  logic [31:0] p_data [2];

  // Reference model: abstract view of the block.
  bit          m_clear;
  int          m_left;      // clear writes still to come
  bit          m_prio;
  bit          m_last;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [1:0]  m_grant;     // grant expected in the current cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check readies, advance model at the edge,
  // check registered outputs, retire granted requests.
  task automatic step();
    @(negedge clk);
    bus.req0_valid = p_valid[0];
    bus.req0_rd    = p_rd[0];
    bus.req0_data  = p_data[0];
    bus.req1_valid = p_valid[1];
    bus.req1_rd    = p_rd[1];
    bus.req1_data  = p_data[1];
    #1;
    m_grant = 2'b00;
    if (rst && !m_clear && !clr_start) begin
      if (p_valid == 2'b11) m_grant[m_prio] = 1'b1;
      else                  m_grant = p_valid;
    end
    check("ready0", 32'(bus.req0_ready), 32'(m_grant[0]));
    check("ready1", 32'(bus.req1_ready), 32'(m_grant[1]));
    check("busy_pre", 32'(clr_busy), 32'(m_clear));
    $display("cyc t=%0t rst=%0b clr=%0b v=%02b exp_grant=%02b", $time, rst, clr_start, p_valid, m_grant);
    @(posedge clk);
    if (!rst) begin
      m_clear = 0; m_left = 0; m_prio = 0; m_last = 0;
      m_wen = 0; m_rd = 0; m_data = 0;
    end else if (m_clear) begin
      m_wen  = 1;
      m_rd   = 5'(32 - m_left);
      m_data = 0;
      m_left--;
      if (m_left == 0) m_clear = 0;
    end else if (clr_start) begin
      m_clear = 1; m_left = 31; m_wen = 0;
    end else if (m_grant != 2'b00) begin
      int g;
      g = m_grant[1] ? 1 : 0;
      m_prio = (g == 0);
      m_last = (g == 1);
      if (p_rd[g] != 5'd0) begin
        m_wen = 1; m_rd = p_rd[g]; m_data = p_data[g];
      end else begin
        m_wen = 0;
      end
      p_valid[g] = 1'b0;
    end else begin
      m_wen = 0;
    end
    #1;
    check("wr_en", 32'(wr_en), 32'(m_wen));
    check("rd", 32'(wr_rd), 32'(m_rd));
    check("wr_data", wr_data, m_data);
    check("last_grant", 32'(last_grant), 32'(m_last));
    check("busy_post", 32'(clr_busy), 32'(m_clear));
  endtask

  task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
    p_valid[i] = 1'b1;
    p_rd[i]    = r;
    p_data[i]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int clr_writes;
    int wr_count;
    rst = 1'b0; clr_start = 1'b0;
    p_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin p_rd[i] = 0; p_data[i] = 0; end
    m_clear = 0; m_left = 0; m_prio = 0; m_last = 0; m_wen = 0; m_rd = 0; m_data = 0;

    // Reset and single request from requester 0.
    do_reset();
    set_req(0, 5'd5, 32'hA5A5A5A5);
    step();
    check("d_single_rd", 32'(wr_rd), 32'd5);
    check("d_single_data", wr_data, 32'hA5A5A5A5);
    step();

    // Both requesters continuously valid: alternating grants.
    do_reset();
    wr_count = 0;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 5'd3, 32'h3333_0000 + 32'(c));
      set_req(1, 5'd4, 32'h4444_0000 + 32'(c));
      step();
      check("d_alt_grant", 32'(last_grant), 32'(c % 2));
      check("d_alt_rd", 32'(wr_rd), (c % 2 == 0) ? 32'd3 : 32'd4);
      if (wr_en) wr_count++;
    end
    check("d_alt_writes", 32'(wr_count), 32'd4);
    p_valid = 2'b00;
    step();

    // Requester 1 writes x0: consumed, no write, priority back to 0.
    set_req(1, 5'd0, 32'hFFFFFFFF);
    step();
    check("d_x0_wen", 32'(wr_en), 32'd0);
    set_req(0, 5'd7, 32'h7);
    set_req(1, 5'd8, 32'h8);
    step();
    check("d_x0_prio", 32'(last_grant), 32'd0);
    p_valid = 2'b00;
    step();

    // Clear with a simultaneous request: clear wins, request granted after.
    set_req(0, 5'd9, 32'h9999);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    clr_writes = 0;
    for (int c = 0; c < 31; c++) begin
      step();
      if (wr_en && wr_data == 0 && wr_rd == 5'(c + 1)) clr_writes++;
    end
    check("d_clear_writes", 32'(clr_writes), 32'd31);
    step();
    check("d_after_clear_rd", 32'(wr_rd), 32'd9);

    // Reset during clear, right after the 10th clear write.
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("d_abort_pre_rd", 32'(wr_rd), 32'd10);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("d_abort_wen", 32'(wr_en), 32'd0);
    check("d_abort_busy", 32'(clr_busy), 32'd0);
    step();
    check("d_abort_no11", 32'(wr_rd == 5'd11), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && ($urandom_range(0, 1) == 1))
          set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      end
      clr_start = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1; clr_start = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
